// File: rtl/ddr3_frame_reader.sv
// ddr3_frame_reader: CSR-programmed N-buffer frame fetcher with Avalon-MM bursts,
// credit-guarded beat FIFO and SOF/EOF stream. Option macro: REPEAT_LAST_FRAME_EN.
module ddr3_frame_reader #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int BURST_W    = 10,
  parameter int MAX_BURST  = 64,
  parameter int NUM_BUF    = 2,
  parameter int FIFO_DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_write,
  input  logic               csr_read,
  input  logic [3:0]         csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  output logic [BURST_W-1:0] avm_burstcount,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [DATA_W-1:0]  st_data,
  output logic               st_valid,
  input  logic               st_ready,
  output logic               st_sof,
  output logic               st_eof,
  output logic               frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = DATA_W + 2;
  localparam int BYTES  = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        base_q, base_d;
  logic [31:0]        stride_q, stride_d;
  logic [31:0]        beats_q, beats_d;
  logic               enable_q, enable_d;
  logic [NUM_BUF-1:0] ready_q, ready_d;
  logic [1:0]         cur_q, cur_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [1:0]         buf_q, buf_d;
  logic               rep_q, rep_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        remain_q, remain_d;
  logic [31:0]        fbeats_q, fbeats_d;
  logic [31:0]        idx_q, idx_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;

  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   used_q, used_d;
  logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];

  logic [BURST_W-1:0] len;
  logic [CNT_W-1:0]   free;
  logic               credit_ok;
  logic               read_o;
  logic               accept;
  logic               push;
  logic               pop;
  logic               burst_end;
  logic               last_burst;
  logic               sel_hit;
  logic [1:0]         sel_buf;
  logic [2:0]         cand;
  logic               repeat_ok;
  logic               start;
  logic [1:0]         pick;
  logic [3:0]         rdy4;
  logic [3:0]         onehot;
  logic [NUM_BUF-1:0] clr_mask;
  logic [NUM_BUF-1:0] set_mask;
  logic [WORD_W-1:0]  push_word;
  logic [WORD_W-1:0]  head;

  always_comb begin
    if (remain_q >= 32'(MAX_BURST)) len = BURST_W'(MAX_BURST);
    else len = BURST_W'(remain_q);
  end

  assign free       = CNT_W'(FIFO_DEPTH) - used_q;
  assign credit_ok  = 32'(free) >= 32'(len);
  assign accept     = read_o && !avm_waitrequest;
  assign push       = (state_q == S_WAIT) && avm_readdatavalid;
  assign pop        = st_valid && st_ready;
  assign burst_end  = push && (bcnt_q == len - BURST_W'(1));
  assign last_burst = remain_q == 32'(len);

  // nearest ready buffer after cur_buf wins; scan far-to-near so near overrides
  always_comb begin
    sel_hit = 1'b0;
    sel_buf = cur_q;
    cand    = 3'd0;
    rdy4    = 4'(ready_q);
    for (int i = NUM_BUF; i >= 1; i--) begin
      cand = 3'(cur_q) + 3'(i);
      if (cand >= 3'(NUM_BUF)) cand = cand - 3'(NUM_BUF);
      if (rdy4[cand[1:0]]) begin
        sel_hit = 1'b1;
        sel_buf = cand[1:0];
      end
    end
  end

`ifdef REPEAT_LAST_FRAME_EN
  assign repeat_ok = fcnt_q != 16'd0;
`else
  assign repeat_ok = 1'b0;
`endif

  assign start = (beats_q != 32'd0) && (sel_hit || repeat_ok);
  assign pick  = sel_hit ? sel_buf : cur_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_q) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!enable_q) state_d = S_IDLE;
        else if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (burst_end) begin
          if (last_burst) state_d = S_DONE;
          else if (enable_q) state_d = S_ISSUE;
          else state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_SELECT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_o     = (state_q == S_ISSUE) && credit_ok;
    frame_done = state_q == S_DONE;
  end

  assign avm_read       = read_o;
  assign avm_address    = addr_q;
  assign avm_burstcount = len;

  always_comb begin
    buf_d    = buf_q;
    rep_d    = rep_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    fbeats_d = fbeats_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    fcnt_d   = fcnt_q;
    cur_d    = cur_q;
    if (state_q == S_SELECT && state_d == S_ISSUE) begin
      buf_d    = pick;
      rep_d    = !sel_hit;
      addr_d   = ADDR_W'(base_q + 32'(pick) * stride_q);
      remain_d = beats_q;
      fbeats_d = beats_q;
      idx_d    = 32'd0;
      bcnt_d   = '0;
    end
    if (push) begin
      idx_d  = idx_q + 32'd1;
      bcnt_d = burst_end ? '0 : bcnt_q + BURST_W'(1);
    end
    if (burst_end) begin
      addr_d   = addr_q + ADDR_W'(32'(len) * BYTES);
      remain_d = remain_q - 32'(len);
    end
    if (state_q == S_DONE) begin
      fcnt_d = fcnt_q + 16'd1;
      cur_d  = buf_q;
    end
  end

  // a software set in the same cycle as the hardware clear wins
  always_comb begin
    onehot   = 4'b0001 << buf_q;
    clr_mask = '0;
    set_mask = '0;
    if (state_q == S_DONE && !rep_q) clr_mask = onehot[NUM_BUF-1:0];
    if (csr_write && csr_addr == 4'd4) set_mask = csr_wdata[NUM_BUF-1:0];
    ready_d = (ready_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    base_d   = base_q;
    stride_d = stride_q;
    beats_d  = beats_q;
    enable_d = enable_q;
    if (csr_write) begin
      unique case (1'b1)
        csr_addr == 4'd0: base_d   = csr_wdata;
        csr_addr == 4'd1: stride_d = csr_wdata;
        csr_addr == 4'd2: beats_d  = csr_wdata;
        csr_addr == 4'd3: enable_d = csr_wdata[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (csr_read) begin
      case (csr_addr)
        4'd0:    rdata_d = base_q;
        4'd1:    rdata_d = stride_q;
        4'd2:    rdata_d = beats_q;
        4'd3:    rdata_d = {31'd0, enable_q};
        4'd4:    rdata_d = 32'(ready_q);
        4'd5:    rdata_d = {fcnt_q, 13'd0, state_q != S_IDLE, cur_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  assign csr_rdata = rdata_q;

  always_comb begin
    push_word = {idx_q == 32'd0, idx_q == fbeats_q - 32'd1, avm_readdata};
    wr_d      = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d      = pop ? rd_q + PTR_W'(1) : rd_q;
    used_d    = used_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign head     = mem_q[rd_q];
  assign st_valid = used_q != '0;
  assign st_data  = head[DATA_W-1:0];
  assign st_eof   = head[DATA_W];
  assign st_sof   = head[DATA_W+1];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      stride_q <= '0;
      beats_q  <= '0;
      enable_q <= 1'b0;
      ready_q  <= '0;
      cur_q    <= '0;
      fcnt_q   <= '0;
      rdata_q  <= '0;
      buf_q    <= '0;
      rep_q    <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      fbeats_q <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      used_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      beats_q  <= beats_d;
      enable_q <= enable_d;
      ready_q  <= ready_d;
      cur_q    <= cur_d;
      fcnt_q   <= fcnt_d;
      rdata_q  <= rdata_d;
      buf_q    <= buf_d;
      rep_q    <= rep_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      fbeats_q <= fbeats_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      used_q   <= used_d;
    end
  end

endmodule
